// File: rtl/accum_block_id_walker.sv
// accum_block_id_walker
// Consumes one accumulation-block descriptor, walks its config-id range
// [beg,end) issuing one rdy/ack command per id with the latched offsets,
// and pulses blkdone_dval once per finished or skipped block.
module accum_block_id_walker #(
   parameter int unsigned WBW   = 16,
   parameter int unsigned VDIM  = 6,
   parameter int unsigned ID_BW = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  abofs_rdy,
   output logic                  abofs_ack,
   input  logic [WBW*VDIM-1:0]   i_bofs,
   input  logic [WBW*VDIM-1:0]   i_aofs_beg,
   input  logic [WBW*VDIM-1:0]   i_aofs_end,
   input  logic [ID_BW-1:0]      i_beg,
   input  logic [ID_BW-1:0]      i_end,
   output logic                  dst_rdy,
   input  logic                  dst_ack,
   output logic [WBW*VDIM-1:0]   o_bofs,
   output logic [WBW*VDIM-1:0]   o_aofs_beg,
   output logic [WBW*VDIM-1:0]   o_aofs_end,
   output logic [ID_BW-1:0]      o_id,
   output logic                  o_islast,
   output logic                  blkdone_dval
);

   localparam logic [0:0]       S_IDLE = 1'b0;
   localparam logic [0:0]       S_BUSY = 1'b1;
   localparam logic [ID_BW-1:0] ONE_ID = {{(ID_BW-1){1'b0}}, 1'b1};

   logic [0:0]          r_state;
   logic [WBW*VDIM-1:0] r_bofs;
   logic [WBW*VDIM-1:0] r_aofs_beg;
   logic [WBW*VDIM-1:0] r_aofs_end;
   logic [ID_BW-1:0]    r_id;
   logic [ID_BW-1:0]    r_end;
   logic [1:0]          r_pend;
   logic                r_dval;

   logic                w_busy;
   logic                w_islast;
   logic                w_accept;
   logic                w_nonempty;
   logic                w_done;
   logic                w_skip;
   logic [2:0]          w_tot;
   logic [2:0]          w_tot_m1;

   assign w_busy     = (r_state == S_BUSY);
   assign w_islast   = w_busy && (r_id == (r_end - ONE_ID));
   assign w_accept   = abofs_rdy && (!w_busy || (dst_ack && w_islast));
   assign w_nonempty = (i_beg < i_end);
   assign w_done     = w_busy && dst_ack && w_islast;
   assign w_skip     = w_accept && !w_nonempty;

   // A finishing block and a skipped block in the same cycle give two
   // events; the surplus is parked in a pending count and drained one
   // pulse per cycle.
   assign w_tot    = {1'b0, r_pend} + {2'b00, w_done} + {2'b00, w_skip};
   assign w_tot_m1 = w_tot - 3'd1;

   assign abofs_ack    = w_accept;
   assign dst_rdy      = w_busy;
   assign o_islast     = w_islast;
   assign o_bofs       = r_bofs;
   assign o_aofs_beg   = r_aofs_beg;
   assign o_aofs_end   = r_aofs_end;
   assign o_id         = r_id;
   assign blkdone_dval = r_dval;

   // FSM, descriptor latch and id walk
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_bofs     <= '0;
         r_aofs_beg <= '0;
         r_aofs_end <= '0;
         r_id       <= '0;
         r_end      <= '0;
      end else if (w_accept) begin
         r_bofs     <= i_bofs;
         r_aofs_beg <= i_aofs_beg;
         r_aofs_end <= i_aofs_end;
         r_id       <= i_beg;
         r_end      <= i_end;
         r_state    <= w_nonempty ? S_BUSY : S_IDLE;
      end else if (w_busy && dst_ack) begin
         if (w_islast) begin
            r_state <= S_IDLE;
         end else begin
            r_id <= r_id + ONE_ID;
         end
      end
   end

   // Block-done pulse generation with saturating pending count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dval <= 1'b0;
         r_pend <= '0;
      end else begin
         r_dval <= (w_tot != 3'd0);
         if (w_tot == 3'd0) begin
            r_pend <= '0;
         end else if (w_tot_m1 > 3'd2) begin
            r_pend <= 2'd2;
         end else begin
            r_pend <= w_tot_m1[1:0];
         end
      end
   end

endmodule

// File: tb/tb_accum_block_id_walker.sv
// Directed testbench for accum_block_id_walker.
module tb_accum_block_id_walker;

   localparam int unsigned WBW   = 16;
   localparam int unsigned VDIM  = 6;
   localparam int unsigned ID_BW = 4;
   localparam int unsigned OW    = WBW * VDIM;

   localparam logic [OW-1:0] PAT_B0 = {16'd16, 16'd17, 16'd18, 16'd19, 16'd20, 16'd21};
   localparam logic [OW-1:0] PAT_A0 = {16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
   localparam logic [OW-1:0] PAT_E0 = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
   localparam logic [OW-1:0] PAT_B1 = {16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};

   logic              clk;
   logic              rst_n;
   logic              abofs_rdy;
   logic              abofs_ack;
   logic [OW-1:0]     bofs, aofs_beg, aofs_end;
   logic [ID_BW-1:0]  beg_id, end_id;
   logic              dst_rdy;
   logic              dst_ack;
   logic [OW-1:0]     o_bofs, o_aofs_beg, o_aofs_end;
   logic [ID_BW-1:0]  o_id;
   logic              o_islast;
   logic              blkdone_dval;

   int unsigned total = 0;
   int unsigned bad   = 0;

   accum_block_id_walker #(.WBW(WBW), .VDIM(VDIM), .ID_BW(ID_BW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .abofs_rdy    (abofs_rdy),
      .abofs_ack    (abofs_ack),
      .i_bofs       (bofs),
      .i_aofs_beg   (aofs_beg),
      .i_aofs_end   (aofs_end),
      .i_beg        (beg_id),
      .i_end        (end_id),
      .dst_rdy      (dst_rdy),
      .dst_ack      (dst_ack),
      .o_bofs       (o_bofs),
      .o_aofs_beg   (o_aofs_beg),
      .o_aofs_end   (o_aofs_end),
      .o_id         (o_id),
      .o_islast     (o_islast),
      .blkdone_dval (blkdone_dval)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [ID_BW-1:0] b, input logic [ID_BW-1:0] e, input logic [OW-1:0] pb);
      abofs_rdy = 1'b1;
      beg_id    = b;
      end_id    = e;
      bofs      = pb;
      aofs_beg  = PAT_A0;
      aofs_end  = PAT_E0;
   endtask

   initial begin
      logic [ID_BW-1:0] exp_id;
      logic             done;
      int unsigned      pulses;

      rst_n = 1'b0; abofs_rdy = 1'b0; dst_ack = 1'b0;
      bofs = '0; aofs_beg = '0; aofs_end = '0; beg_id = '0; end_id = '0;
      #12;
      chk("rst_dst_rdy", dst_rdy, 0);
      chk("rst_o_id", o_id, 0);
      chk("rst_islast", o_islast, 0);
      chk("rst_blkdone", blkdone_dval, 0);
      chk("rst_bofs", o_bofs, 0);
      chk("rst_abofs_ack", abofs_ack, 0);
      rst_n = 1'b1;
      tick;

      // 1: range 2..4 with dst_ack always high
      present(4'd2, 4'd5, PAT_B0);
      #1 chk("t1_accept", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0; dst_ack = 1'b1;
      #1;
      chk("t1_bofs", o_bofs, PAT_B0);
      chk("t1_aofs_beg", o_aofs_beg, PAT_A0);
      chk("t1_aofs_end", o_aofs_end, PAT_E0);
      for (int unsigned k = 2; k < 5; k++) begin
         chk("t1_rdy", dst_rdy, 1);
         chk("t1_id", o_id, k);
         chk("t1_islast", o_islast, (k == 4));
         chk("t1_nodone", blkdone_dval, 0);
         tick;
      end
      dst_ack = 1'b0;
      #1;
      chk("t1_idle", dst_rdy, 0);
      chk("t1_done", blkdone_dval, 1);
      chk("t1_islast_idle", o_islast, 0);
      tick;
      chk("t1_done_once", blkdone_dval, 0);

      // 2: empty and inverted ranges are skipped
      present(4'd3, 4'd3, PAT_B1);
      #1 chk("t2a_accept", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0;
      #1;
      chk("t2a_rdy", dst_rdy, 0);
      chk("t2a_done", blkdone_dval, 1);
      tick;
      chk("t2a_done_once", blkdone_dval, 0);
      present(4'd5, 4'd1, PAT_B1);
      #1 chk("t2b_accept", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0;
      #1;
      chk("t2b_rdy", dst_rdy, 0);
      chk("t2b_done", blkdone_dval, 1);
      chk("t2b_noack", abofs_ack, 0);
      tick;
      chk("t2b_done_once", blkdone_dval, 0);

      // 3: back-to-back blocks 0..1 then 4..5, zero bubble
      present(4'd0, 4'd2, PAT_B0);
      #1 chk("t3_acceptA", abofs_ack, 1);
      tick;
      present(4'd4, 4'd6, PAT_B1);
      dst_ack = 1'b1;
      #1;
      chk("t3_id0", o_id, 0);
      chk("t3_holdB", abofs_ack, 0);
      tick;
      chk("t3_id1", o_id, 1);
      chk("t3_islast1", o_islast, 1);
      chk("t3_acceptB", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0;
      #1;
      chk("t3_rdy_cont", dst_rdy, 1);
      chk("t3_id4", o_id, 4);
      chk("t3_bofsB", o_bofs, PAT_B1);
      chk("t3_doneA", blkdone_dval, 1);
      tick;
      chk("t3_id5", o_id, 5);
      chk("t3_islast5", o_islast, 1);
      chk("t3_gap", blkdone_dval, 0);
      tick;
      dst_ack = 1'b0;
      #1;
      chk("t3_idle", dst_rdy, 0);
      chk("t3_doneB", blkdone_dval, 1);
      tick;

      // 3b: block end coincides with a skipped accept -> two pulses
      present(4'd0, 4'd1, PAT_B0);
      #1 chk("t3b_acceptA", abofs_ack, 1);
      tick;
      present(4'd7, 4'd7, PAT_B1);
      dst_ack = 1'b1;
      #1 chk("t3b_acceptSkip", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0; dst_ack = 1'b0;
      #1;
      chk("t3b_idle", dst_rdy, 0);
      chk("t3b_pulse1", blkdone_dval, 1);
      tick;
      chk("t3b_pulse2", blkdone_dval, 1);
      tick;
      chk("t3b_pulse_end", blkdone_dval, 0);

      // 4: random downstream acks on range 3..8
      present(4'd3, 4'd9, PAT_B1);
      #1 chk("t4_accept", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0;
      exp_id = 4'd3; done = 1'b0; pulses = 0;
      for (int unsigned c = 0; c < 300 && !done; c++) begin
         if (blkdone_dval) begin
            pulses++;
            done = 1'b1;
         end
         if (dst_rdy) begin
            chk("t4_id", o_id, exp_id);
            chk("t4_bofs_stable", o_bofs, PAT_B1);
            chk("t4_islast", o_islast, (exp_id == 4'd8));
            dst_ack = ($urandom_range(0, 9) < 3);
            if (dst_ack) exp_id = exp_id + 4'd1;
         end else begin
            dst_ack = 1'b0;
         end
         tick;
      end
      dst_ack = 1'b0;
      chk("t4_finished", done, 1);
      chk("t4_all_ids", exp_id, 9);
      chk("t4_pulses", pulses, 1);

      // 5: async reset in the middle of range 0..14
      present(4'd0, 4'd15, PAT_B0);
      #1 chk("t5_accept", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0; dst_ack = 1'b1;
      repeat (7) tick;
      chk("t5_id7", o_id, 7);
      rst_n = 1'b0;
      dst_ack = 1'b0;
      #1;
      chk("t5_rdy_drop", dst_rdy, 0);
      chk("t5_id_clr", o_id, 0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("t5_nodone", blkdone_dval, 0);
      tick;
      chk("t5_nodone2", blkdone_dval, 0);
      present(4'd1, 4'd3, PAT_B0);
      #1 chk("t5_accept2", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0; dst_ack = 1'b1;
      #1;
      chk("t5_id1", o_id, 1);
      tick;
      chk("t5_id2", o_id, 2);
      chk("t5_islast2", o_islast, 1);
      tick;
      dst_ack = 1'b0;
      #1;
      chk("t5_done", blkdone_dval, 1);
      tick;

      // 6: top-of-range ids 13..14, no wrap
      present(4'd13, 4'd15, PAT_B0);
      #1 chk("t6_accept", abofs_ack, 1);
      tick;
      abofs_rdy = 1'b0; dst_ack = 1'b1;
      #1;
      chk("t6_id13", o_id, 13);
      chk("t6_islast13", o_islast, 0);
      tick;
      chk("t6_id14", o_id, 14);
      chk("t6_islast14", o_islast, 1);
      tick;
      dst_ack = 1'b0;
      #1;
      chk("t6_idle", dst_rdy, 0);
      chk("t6_nowrap", o_id, 14);
      chk("t6_done", blkdone_dval, 1);
      tick;
      chk("t6_done_once", blkdone_dval, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
